vm_multi_item_ctrl: RTL

VM_MULTI_ITEM_CTRL -- requirements
Module: vm_multi_item_ctrl

---
 rtl/vm_multi_pkg.sv | 43 ++++
 rtl/vm_timeout_timer.sv | 27 ++
 rtl/vm_multi_item_ctrl.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/vm_multi_pkg.sv
// Shared types for the multi-item vending controller: FSM states,
// status codes, coin encodings and coin values in cents.
package vm_multi_pkg;

    typedef enum logic [5:0] {
        ST_IDLE          = 6'b000001,
        ST_RESTOCK       = 6'b000010,
        ST_CHECK_ITEM    = 6'b000100,
        ST_INSERT_COINS  = 6'b001000,
        ST_CHECK_BALANCE = 6'b010000,
        ST_DISPENSE      = 6'b100000
    } state_t;

    typedef enum logic [1:0] {
        STAT_IDLE         = 2'd0,
        STAT_AVAILABLE    = 2'd1,
        STAT_OUT_OF_STOCK = 2'd2,
        STAT_ERROR        = 2'd3
    } status_t;

    typedef enum logic [1:0] {
        COIN_NONE    = 2'b00,
        COIN_NICKEL  = 2'b01,
        COIN_DIME    = 2'b10,
        COIN_QUARTER = 2'b11
    } coin_t;

    localparam int NICKEL_VAL  = 5;
    localparam int DIME_VAL    = 10;
    localparam int QUARTER_VAL = 25;

    function automatic logic [4:0] coin_value(input coin_t c);
        logic [4:0] v;
        unique case (c)
            COIN_NICKEL:  v = 5'(NICKEL_VAL);
            COIN_DIME:    v = 5'(DIME_VAL);
            COIN_QUARTER: v = 5'(QUARTER_VAL);
            default:      v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/vm_timeout_timer.sv
// Watchdog down-counter for the coin-insertion phase.
// Ports: clk, hrst (sync, active-high), load (reload to TIMEOUT_CYC),
// en (count down one step), expired (counter is at zero).
module vm_timeout_timer #(
    parameter int TIMEOUT_CYC = 255,
    localparam int TW = $clog2(TIMEOUT_CYC + 1)
) (
    input  logic clk,
    input  logic hrst,
    input  logic load,
    input  logic en,
    output logic expired
);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (hrst || load) begin
            cnt <= TW'(TIMEOUT_CYC);
        end else if (en && cnt != '0) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/vm_multi_item_ctrl.sv
// Multi-item vending controller: restock, item check, coin collection,
// balance check and dispense, with per-slot stock and price registers.
// Inputs: clk, hrst (sync hard reset), srst (cancel), valid/item/count/cost
// (restock), sel_vld/sel_idx (selection), coins, select (confirm).
// Outputs: product_vld/product, balance, status, info, insert_coins,
// refund_vld/refund. Define VM_REFUND_EN to refund on cancel/timeout;
// otherwise the collected amount is kept as credit.
module vm_multi_item_ctrl
    import vm_multi_pkg::*;
#(
    parameter int N_ITEMS     = 8,
    parameter int CNT_W       = 5,
    parameter int MAX_STOCK   = 16,
    parameter int COST_W      = 16,
    parameter int TIMEOUT_CYC = 255,
    localparam int IDX_W      = $clog2(N_ITEMS)
) (
    input  logic              clk,
    input  logic              hrst,
    input  logic              srst,
    input  logic              valid,
    input  logic [IDX_W-1:0]  item,
    input  logic [CNT_W-1:0]  count,
    input  logic [COST_W-1:0] cost,
    input  logic              sel_vld,
    input  logic [IDX_W-1:0]  sel_idx,
    input  logic [1:0]        coins,
    input  logic              select,
    output logic              product_vld,
    output logic [IDX_W-1:0]  product,
    output logic [COST_W-1:0] balance,
    output logic [1:0]        status,
    output logic [COST_W-1:0] info,
    output logic              insert_coins,
    output logic              refund_vld,
    output logic [COST_W-1:0] refund
);

    state_t state, state_n;

    logic [CNT_W-1:0]  stock [N_ITEMS];
    logic [COST_W-1:0] price [N_ITEMS];

    logic [IDX_W-1:0]  sel_q, sel_n;
    logic [COST_W-1:0] amount, amount_n;
    logic [COST_W-1:0] balance_n, info_n;
    logic [1:0]        status_n;
    logic              product_vld_n;
    logic [IDX_W-1:0]  product_n;

    logic              stock_we, price_we;
    logic [IDX_W-1:0]  stock_idx;
    logic [CNT_W-1:0]  stock_wd;

    logic [CNT_W:0]    rs_sum;
    logic [COST_W:0]   coin_sum;
    logic [COST_W-1:0] amt_in, cancel_amt;
    logic              in_ins, cancel;
    logic              timer_load, timer_en, expired;

    assign in_ins       = (state == ST_INSERT_COINS);
    assign insert_coins = in_ins;

`ifdef VM_REFUND_EN
    logic              refund_vld_n;
    logic [COST_W-1:0] refund_n;
`endif

    vm_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk     (clk),
        .hrst    (hrst),
        .load    (timer_load),
        .en      (timer_en),
        .expired (expired)
    );

    always_comb begin
        rs_sum   = {1'b0, stock[item]} + {1'b0, count};
        coin_sum = {1'b0, amount}
                 + (COST_W+1)'(coin_value(coin_t'(coins)));
        // Saturate the running amount at all-ones.
        amt_in   = coin_sum[COST_W] ? '1 : coin_sum[COST_W-1:0];
        // A coin in the cancel/timeout cycle is already part of amt_in.
        cancel     = (srst && state != ST_IDLE)
                   || (in_ins && expired && !select);
        cancel_amt = in_ins ? amt_in : amount;

        state_n       = state;
        sel_n         = sel_q;
        amount_n      = amount;
        balance_n     = balance;
        info_n        = info;
        status_n      = status;
        product_vld_n = 1'b0;
        product_n     = product;
        stock_we      = 1'b0;
        stock_idx     = item;
        stock_wd      = rs_sum[CNT_W-1:0];
        price_we      = 1'b0;
        timer_load    = 1'b0;
`ifdef VM_REFUND_EN
        refund_vld_n  = 1'b0;
        refund_n      = '0;
`endif

        if (cancel) begin
            state_n = ST_IDLE;
`ifdef VM_REFUND_EN
            amount_n     = '0;
            refund_vld_n = (cancel_amt != '0);
            refund_n     = cancel_amt;
`else
            amount_n = cancel_amt;
`endif
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (valid) begin
                        state_n = ST_RESTOCK;
                    end else if (sel_vld) begin
                        state_n   = ST_CHECK_ITEM;
                        sel_n     = sel_idx;
                        balance_n = '0;
                    end
                end
                ST_RESTOCK: begin
                    if (!valid) begin
                        state_n = ST_IDLE;
                    end else begin
                        if (rs_sum > (CNT_W+1)'(MAX_STOCK)) begin
                            status_n = STAT_ERROR;
                        end else begin
                            stock_we = 1'b1;
                        end
                        price_we = (cost != '0);
                    end
                end
                ST_CHECK_ITEM: begin
                    if (stock[sel_q] != '0) begin
                        status_n   = STAT_AVAILABLE;
                        info_n     = price[sel_q];
                        state_n    = ST_INSERT_COINS;
                        timer_load = 1'b1;
                    end else begin
                        status_n = STAT_OUT_OF_STOCK;
                        state_n  = ST_IDLE;
                    end
                end
                ST_INSERT_COINS: begin
                    amount_n   = amt_in;
                    timer_load = (coins != 2'b00);
                    if (select) begin
                        state_n = ST_CHECK_BALANCE;
                    end
                end
                ST_CHECK_BALANCE: begin
                    if (amount >= price[sel_q]) begin
                        balance_n     = amount - price[sel_q];
                        product_vld_n = 1'b1;
                        product_n     = sel_q;
                        stock_we      = 1'b1;
                        stock_idx     = sel_q;
                        stock_wd      = stock[sel_q] - CNT_W'(1);
                        amount_n      = '0;
                        state_n       = ST_DISPENSE;
                    end else begin
                        state_n    = ST_INSERT_COINS;
                        timer_load = 1'b1;
                    end
                end
                ST_DISPENSE: begin
                    state_n = ST_IDLE;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        timer_en = in_ins && !timer_load;
    end

    always_ff @(posedge clk) begin
        if (hrst) begin
            state       <= ST_IDLE;
            sel_q       <= '0;
            amount      <= '0;
            balance     <= '0;
            info        <= '0;
            status      <= STAT_IDLE;
            product_vld <= 1'b0;
            product     <= '0;
            for (int i = 0; i < N_ITEMS; i++) begin
                stock[i] <= '0;
                price[i] <= '0;
            end
        end else begin
            state       <= state_n;
            sel_q       <= sel_n;
            amount      <= amount_n;
            balance     <= balance_n;
            info        <= info_n;
            status      <= status_n;
            product_vld <= product_vld_n;
            product     <= product_n;
            if (stock_we) begin
                stock[stock_idx] <= stock_wd;
            end
            if (price_we) begin
                price[item] <= cost;
            end
        end
    end

`ifdef VM_REFUND_EN
    always_ff @(posedge clk) begin
        if (hrst) begin
            refund_vld <= 1'b0;
            refund     <= '0;
        end else begin
            refund_vld <= refund_vld_n;
            refund     <= refund_n;
        end
    end
`else
    assign refund_vld = 1'b0;
    assign refund     = '0;
`endif

endmodule
